// File: rtl/synth_step_sequencer.sv
// synth_step_sequencer: pattern step sequencer sharing the config byte bus with a host write port
module synth_step_sequencer #(
  parameter int NUM_STEPS  = 16,
  parameter int TEMPO_BITS = 16,
  parameter int CFG_BYTES  = 6,
  localparam int SW = $clog2(NUM_STEPS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  run,
  input  logic [TEMPO_BITS-1:0] tempo,
  input  logic [SW-1:0]         length,
  input  logic                  pat_we,
  input  logic [SW-1:0]         pat_addr,
  input  logic [15:0]           pat_data,
  input  logic                  host_valid,
  output logic                  host_ready,
  input  logic [2:0]            host_addr,
  input  logic [7:0]            host_data,
  output logic [7:0]            cfg_data,
  output logic [CFG_BYTES-1:0]  cfg_en,
  output logic [SW-1:0]         step_idx,
  output logic                  step_pulse
);
  typedef enum logic [1:0] {IDLE, WR_LO, WR_HI, WAIT} state_t;

  state_t                r_state, w_next;
  logic [15:0]           r_mem [NUM_STEPS];
  logic [7:0]            r_hold;
  logic [TEMPO_BITS-1:0] r_tick;
  logic [SW-1:0]         r_step;
  logic [7:0]            r_cfg_data;
  logic [CFG_BYTES-1:0]  r_cfg_en;
  logic                  r_pulse;
  logic                  w_host_ready, w_host_wr, w_host_ok;

  // The two sequencer write cycles own the bus; the host may write at any other time.
  assign w_host_ready = (r_state != WR_LO) && (r_state != WR_HI);
  assign w_host_wr    = host_valid && w_host_ready;
  assign w_host_ok    = 32'(host_addr) < CFG_BYTES;

  assign host_ready = w_host_ready;
  assign cfg_data   = r_cfg_data;
  assign cfg_en     = r_cfg_en;
  assign step_idx   = r_step;
  assign step_pulse = r_pulse;

  // Pattern memory: unreset storage, writable in every state.
  always_ff @(posedge clk) begin
    if (pat_we) r_mem[pat_addr] <= pat_data;
  end

  // Next-state logic; a byte-0 write always proceeds to byte-1 regardless of run.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = run ? WR_LO : IDLE;
      WR_LO:   w_next = WR_HI;
      WR_HI:   w_next = run ? WAIT : IDLE;
      default: w_next = !run ? IDLE : (r_tick == '0 ? WR_LO : WAIT);
    endcase
  end

  // State register, frozen while ena is low.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else if (ena) r_state <= w_next;
  end

  // Step/tempo counters, sequencer byte writes and the host write path.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_step     <= '0;
      r_tick     <= '0;
      r_hold     <= '0;
      r_cfg_data <= '0;
      r_cfg_en   <= '0;
      r_pulse    <= 1'b0;
    end else begin
      r_pulse  <= ena && (r_state == WR_LO);
      r_cfg_en <= '0;
      if (ena) begin
        if (r_state == IDLE && run) r_step <= '0;
        if (r_state == WR_HI && run) r_tick <= tempo;
        if (r_state == WAIT && run) begin
          if (r_tick != '0) r_tick <= r_tick - 1'b1;
          else r_step <= (r_step >= length) ? '0 : r_step + 1'b1;
        end
        if (r_state == WR_LO) begin
          r_cfg_data <= r_mem[r_step][7:0];
          r_hold     <= r_mem[r_step][15:8];
          r_cfg_en   <= CFG_BYTES'(1);
        end
        if (r_state == WR_HI) begin
          r_cfg_data <= r_hold;
          r_cfg_en   <= CFG_BYTES'(2);
        end
      end
      if (w_host_wr && w_host_ok) begin
        r_cfg_data <= host_data;
        r_cfg_en   <= CFG_BYTES'(1) << host_addr;
      end
    end
  end
endmodule

// File: tb/tb_synth_step_sequencer.sv
// tb_synth_step_sequencer: directed checks of playback, arbitration, stop, freeze and reset
module tb_synth_step_sequencer;
  logic       clk = 0, rst_n = 0, ena = 1, run = 0, pat_we = 0, host_valid = 0;
  logic [15:0] tempo = 16'd5, pat_data = 16'h0;
  logic [3:0] length = 4'd1, pat_addr = 4'd0;
  logic [2:0] host_addr = 3'd0;
  logic [7:0] host_data = 8'h0;
  logic       host_ready, step_pulse;
  logic [7:0] cfg_data;
  logic [5:0] cfg_en;
  logic [3:0] step_idx;
  int n_vec = 0, n_err = 0;

  synth_step_sequencer dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .run(run), .tempo(tempo), .length(length),
    .pat_we(pat_we), .pat_addr(pat_addr), .pat_data(pat_data),
    .host_valid(host_valid), .host_ready(host_ready), .host_addr(host_addr), .host_data(host_data),
    .cfg_data(cfg_data), .cfg_en(cfg_en), .step_idx(step_idx), .step_pulse(step_pulse)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    tick();
    tick();
    n_vec++;
    if ({cfg_en, cfg_data, step_idx, step_pulse, host_ready} !== {6'h00, 8'h00, 4'h0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL reset: en=%h data=%h idx=%h pulse=%b ready=%b, want 00 00 0 0 1", cfg_en, cfg_data, step_idx, step_pulse, host_ready);
    end
    rst_n = 1;
    pat_we = 1; pat_addr = 4'd0; pat_data = 16'h6038;
    tick();
    pat_addr = 4'd1; pat_data = 16'h8038;
    tick();
    pat_we = 0;
  endtask

  task automatic test_basic_play();
    logic [5:0] exp_en;
    logic [7:0] exp_data;
    logic [3:0] exp_idx;
    run = 1;
    tick();
    n_vec++;
    if ({cfg_en, host_ready, step_idx} !== {6'h00, 1'b0, 4'h0}) begin
      n_err++;
      $display("FAIL play_start: en=%h ready=%b idx=%h, want 00 0 0", cfg_en, host_ready, step_idx);
    end
    for (int c = 1; c <= 20; c++) begin
      tick();
      exp_en   = (c % 8 == 1) ? 6'h01 : (c % 8 == 2) ? 6'h02 : 6'h00;
      exp_data = (c % 8 == 1) ? 8'h38 : (c == 10) ? 8'h80 : 8'h60;
      exp_idx  = (c >= 8 && c < 16) ? 4'd1 : 4'd0;
      n_vec++;
      if ({cfg_en, step_pulse, step_idx} !== {exp_en, c % 8 == 1, exp_idx}) begin
        n_err++;
        $display("FAIL play_c%0d: en=%h pulse=%b idx=%h, want %h %b %h", c, cfg_en, step_pulse, step_idx, exp_en, c % 8 == 1, exp_idx);
      end
      if (exp_en != 6'h00) begin
        n_vec++;
        if (cfg_data !== exp_data) begin
          n_err++;
          $display("FAIL play_data_c%0d: got %h want %h", c, cfg_data, exp_data);
        end
      end
    end
    run = 0;
    tick();
    n_vec++;
    if ({cfg_en, host_ready} !== {6'h00, 1'b1}) begin
      n_err++;
      $display("FAIL play_stop: en=%h ready=%b, want 00 1", cfg_en, host_ready);
    end
  endtask

  task automatic test_host_arbitration();
    run = 1;
    tick();
    host_valid = 1; host_addr = 3'd4; host_data = 8'hA5;
    n_vec++;
    if (host_ready !== 1'b0) begin
      n_err++;
      $display("FAIL arb_ready0: got %b want 0", host_ready);
    end
    tick();
    n_vec++;
    if ({cfg_en, host_ready} !== {6'h01, 1'b0}) begin
      n_err++;
      $display("FAIL arb_lo: en=%h ready=%b, want 01 0", cfg_en, host_ready);
    end
    tick();
    n_vec++;
    if ({cfg_en, cfg_data, host_ready} !== {6'h02, 8'h60, 1'b1}) begin
      n_err++;
      $display("FAIL arb_hi: en=%h data=%h ready=%b, want 02 60 1", cfg_en, cfg_data, host_ready);
    end
    tick();
    n_vec++;
    if ({cfg_en, cfg_data} !== {6'h10, 8'hA5}) begin
      n_err++;
      $display("FAIL arb_host: en=%h data=%h, want 10 a5", cfg_en, cfg_data);
    end
    host_addr = 3'd7; host_data = 8'h11;
    n_vec++;
    if (host_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bad_addr_ready: got %b want 1", host_ready);
    end
    tick();
    n_vec++;
    if ({cfg_en, cfg_data} !== {6'h00, 8'hA5}) begin
      n_err++;
      $display("FAIL bad_addr7: en=%h data=%h, want 00 a5", cfg_en, cfg_data);
    end
    host_addr = 3'd5; host_data = 8'h5A;
    tick();
    n_vec++;
    if ({cfg_en, cfg_data} !== {6'h20, 8'h5A}) begin
      n_err++;
      $display("FAIL addr5: en=%h data=%h, want 20 5a", cfg_en, cfg_data);
    end
    host_addr = 3'd6; host_data = 8'h77;
    tick();
    n_vec++;
    if ({cfg_en, cfg_data} !== {6'h00, 8'h5A}) begin
      n_err++;
      $display("FAIL bad_addr6: en=%h data=%h, want 00 5a", cfg_en, cfg_data);
    end
    host_valid = 0;
    run = 0;
    tick();
    n_vec++;
    if ({cfg_en, host_ready} !== {6'h00, 1'b1}) begin
      n_err++;
      $display("FAIL arb_idle: en=%h ready=%b, want 00 1", cfg_en, host_ready);
    end
  endtask

  task automatic test_stop_mid_write();
    run = 1;
    for (int i = 0; i < 9; i++) tick();
    n_vec++;
    if ({step_idx, host_ready} !== {4'd1, 1'b0}) begin
      n_err++;
      $display("FAIL stop_wrlo: idx=%h ready=%b, want 1 0", step_idx, host_ready);
    end
    run = 0;
    tick();
    n_vec++;
    if ({cfg_en, cfg_data, step_pulse} !== {6'h01, 8'h38, 1'b1}) begin
      n_err++;
      $display("FAIL stop_lo: en=%h data=%h pulse=%b, want 01 38 1", cfg_en, cfg_data, step_pulse);
    end
    tick();
    n_vec++;
    if ({cfg_en, cfg_data} !== {6'h02, 8'h80}) begin
      n_err++;
      $display("FAIL stop_hi: en=%h data=%h, want 02 80", cfg_en, cfg_data);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      n_vec++;
      if ({cfg_en, step_pulse, host_ready, step_idx} !== {6'h00, 1'b0, 1'b1, 4'd1}) begin
        n_err++;
        $display("FAIL stop_quiet_%0d: en=%h pulse=%b ready=%b idx=%h, want 00 0 1 1", i, cfg_en, step_pulse, host_ready, step_idx);
      end
    end
    run = 1;
    tick();
    n_vec++;
    if (step_idx !== 4'd0) begin
      n_err++;
      $display("FAIL restart_idx: got %h want 0", step_idx);
    end
    pat_we = 1; pat_addr = 4'd0; pat_data = 16'h1234;
    tick();
    pat_we = 0;
    n_vec++;
    if ({cfg_en, cfg_data} !== {6'h01, 8'h38}) begin
      n_err++;
      $display("FAIL restart_lo_oldword: en=%h data=%h, want 01 38", cfg_en, cfg_data);
    end
    tick();
    n_vec++;
    if ({cfg_en, cfg_data} !== {6'h02, 8'h60}) begin
      n_err++;
      $display("FAIL restart_hi_oldword: en=%h data=%h, want 02 60", cfg_en, cfg_data);
    end
    run = 0;
    tick();
  endtask

  task automatic test_enable_freeze();
    logic [5:0] exp_en;
    logic [7:0] exp_data;
    run = 1;
    tick();
    tick();
    n_vec++;
    if ({cfg_en, cfg_data, step_pulse} !== {6'h01, 8'h34, 1'b1}) begin
      n_err++;
      $display("FAIL freeze_start: en=%h data=%h pulse=%b, want 01 34 1", cfg_en, cfg_data, step_pulse);
    end
    host_addr = 3'd2; host_data = 8'hC3;
    for (int k = 1; k <= 18; k++) begin
      ena = (k >= 2 && k <= 11) ? 1'b0 : 1'b1;
      host_valid = (k == 4);
      tick();
      exp_en   = (k == 1) ? 6'h02 : (k == 4) ? 6'h04 : (k == 18) ? 6'h01 : 6'h00;
      exp_data = (k == 1) ? 8'h12 : (k == 18) ? 8'h38 : 8'hC3;
      n_vec++;
      if ({cfg_en, step_pulse, host_ready} !== {exp_en, k == 18, k < 17}) begin
        n_err++;
        $display("FAIL freeze_k%0d: en=%h pulse=%b ready=%b, want %h %b %b", k, cfg_en, step_pulse, host_ready, exp_en, k == 18, k < 17);
      end
      if (exp_en != 6'h00) begin
        n_vec++;
        if (cfg_data !== exp_data) begin
          n_err++;
          $display("FAIL freeze_data_k%0d: got %h want %h", k, cfg_data, exp_data);
        end
      end
    end
    ena = 1;
    host_valid = 0;
    n_vec++;
    if (step_idx !== 4'd1) begin
      n_err++;
      $display("FAIL freeze_idx: got %h want 1", step_idx);
    end
  endtask

  task automatic test_reset_mid_run();
    tick();
    n_vec++;
    if ({cfg_en, cfg_data} !== {6'h02, 8'h80}) begin
      n_err++;
      $display("FAIL rmr_hi: en=%h data=%h, want 02 80", cfg_en, cfg_data);
    end
    tick();
    rst_n = 0;
    tick();
    n_vec++;
    if ({cfg_en, cfg_data, step_idx, step_pulse, host_ready} !== {6'h00, 8'h00, 4'h0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL rmr_reset: en=%h data=%h idx=%h pulse=%b ready=%b, want 00 00 0 0 1", cfg_en, cfg_data, step_idx, step_pulse, host_ready);
    end
    rst_n = 1;
    tick();
    n_vec++;
    if ({cfg_en, host_ready, step_idx, step_pulse} !== {6'h00, 1'b0, 4'h0, 1'b0}) begin
      n_err++;
      $display("FAIL rmr_wrlo: en=%h ready=%b idx=%h pulse=%b, want 00 0 0 0", cfg_en, host_ready, step_idx, step_pulse);
    end
    tick();
    n_vec++;
    if ({cfg_en, cfg_data, step_pulse} !== {6'h01, 8'h34, 1'b1}) begin
      n_err++;
      $display("FAIL rmr_resume: en=%h data=%h pulse=%b, want 01 34 1", cfg_en, cfg_data, step_pulse);
    end
    run = 0;
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_basic_play();
    test_host_arbitration();
    test_stop_mid_write();
    test_enable_freeze();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/synth_step_sequencer.md
# synth_step_sequencer

Step sequencer and config-bus arbiter for the synth voice. Plays a programmable 16-entry pattern of 16-bit saw words (period/octave) into config bytes 0–1 at a programmable tempo. Shares the byte-wide config write bus (data byte plus one-hot byte enables) with a host write port. The sequencer has priority, so a host write waits at most two cycles.

## Interface

Parameters:
- `NUM_STEPS`, 16: pattern depth; power of two.
- `TEMPO_BITS`, 16: width of the tempo counter.
- `CFG_BYTES`, 6: number of config byte enables driven.

Ports:
- `clk`  in  1  clock; single clock domain.
- `rst_n`  in  1  reset, synchronous, active-low.
- `ena`  in  1  design enable; low freezes the sequencer FSM and tempo counter; the host port is unaffected.
- `run`  in  1  level; high plays the pattern, low stops it.
- `tempo`  in  TEMPO_BITS  step period, minus 3, in clk cycles.
- `length`  in  log2(NUM_STEPS)  index of the last step; the pattern wraps after it.
- `pat_we`  in  1  pattern memory write strobe.
- `pat_addr`  in  log2(NUM_STEPS)  pattern write address.
- `pat_data`  in  16  pattern word: bits [7:0] go to config byte 0, bits [15:8] to config byte 1.
- `host_valid`  in  1  host write request.
- `host_ready`  out  1  host write accepted this cycle; combinational.
- `host_addr`  in  3  config byte index.
- `host_data`  in  8  config byte value.
- `cfg_data`  out  8  config write data; registered.
- `cfg_en`  out  CFG_BYTES  one-hot byte write enable; registered.
- `step_idx`  out  log2(NUM_STEPS)  current step.
- `step_pulse`  out  1  one-cycle strobe when a step starts; registered.

## Operation

FSM states and transitions (all only when `ena`=1; `ena`=0 holds every register except the host path):
- IDLE → WR_LO when `run`=1. `step_idx` is set to 0, so step 0 plays immediately.
- WR_LO → WR_HI unconditionally.
  - Registers `cfg_data`=mem[step_idx][7:0], `cfg_en`=000001, `step_pulse`=1.
  - Latches mem[step_idx][15:8] into a hold register.
- WR_HI: registers `cfg_data`=hold, `cfg_en`=000010.
  - `run`=1: go to WAIT, loading `tick`=`tempo`.
  - `run`=0: go to IDLE.
- WAIT:
  - `run`=0: go to IDLE.
  - `tick`≠0: decrement `tick`.
  - `tick`=0: advance `step_idx` (0 if `step_idx`≥`length`, else +1) and go to WR_LO.

Host port rules:
- `host_ready` = state∉{WR_LO, WR_HI}.
- On `host_valid`&&`host_ready`: next `cfg_data`=`host_data`, `cfg_en`=onehot(`host_addr`).
- `host_addr`≥CFG_BYTES: the write is accepted but dropped (`cfg_en`=0).

Default outputs: in any cycle with no write, `cfg_en`=0 and `cfg_data` holds its last value.

Pattern memory:
- Written on `pat_we` in any state.
- Not reset; contents are undefined until programmed.
- A write to mem[step_idx] during WR_LO: the emitted bytes use the old word.

## Timing

- Reset values: state IDLE, `cfg_en`=0, `cfg_data`=0, `step_idx`=0, `step_pulse`=0, `tick`=0. `host_ready`=1 in IDLE.
- Latency:
  - `run` rising edge to `cfg_en`=000001: 2 cycles (IDLE→WR_LO edge, then WR_LO→WR_HI edge).
  - Host accept to `cfg_en` visible: 1 cycle.
- Step period: `tempo`+3 cycles per step with `ena` held high; cycles with `ena`=0 add 1 each.
- Writes are never torn: a byte-0 write is always followed by the byte-1 write on the next cycle, even if `run` falls during WR_LO.
- Simultaneous host request and sequencer write: the sequencer wins; `host_ready`=0 for exactly the 2 write cycles.
- Mid-operation reset: all outputs return to reset values on the next edge and no further `cfg_en` pulses are issued.
- Changing `length` below the current `step_idx` makes the next advance wrap to 0. A new `tempo` takes effect at the next WR_HI load.

## Test plan

- **Basic play:** reset; program mem[0]=0x6038, mem[1]=0x8038; `length`=1, `tempo`=5; raise `run`.
  - `cfg_en`=000001 with `cfg_data`=0x38, then 000010 with 0x60.
  - 8 cycles later: 0x38 then 0x80.
  - 8 cycles after that, step 0 again; `step_pulse` every 8 cycles.
- **Host arbitration:** hold `host_valid`=1, `host_addr`=4, `host_data`=0xA5 while the sequencer enters WR_LO.
  - `host_ready`=0 for 2 cycles, then 1.
  - `cfg_en`=010000 with 0xA5 on the cycle after the sequencer's byte-1 write.
- **Invalid host address:** `host_addr`=7 → `host_ready`=1, `cfg_en` stays 0.
- **Stop mid-write:** drop `run` in WR_LO.
  - Byte-1 write still issued, then IDLE, no further pulses.
  - Raise `run` again: restarts at step 0.
- **Enable freeze:** `ena`=0 for 10 cycles during WAIT with `tempo`=5 → step period becomes 18 cycles; host writes still complete during the freeze.
- **Reset mid-run:** assert `rst_n`=0 for 1 cycle during WAIT → `cfg_en`=0, `step_idx`=0, `step_pulse`=0 next cycle, and playback resumes only once `rst_n` is high, `run` is high, and the FSM has passed through IDLE.
